lwr_row_streamer: RTL and testbench

Producer side of the LWR dot-product stream. On `start` it latches one secret-key vector and a row base address, reads `N_LWR` public-matrix elements from a synchronous memory, and emits them as the `a_in`/`a_valid`/`a_last` stream. Each element is paired with its aligned `key_bit`, so the downstream accumulator can consume one element per cycle. It sits between the matrix RAM and the dot-product accumulator in the PRF datapath.

---
 rtl/lwr_row_streamer.sv | 148 ++++++++++++++
 tb/tb_lwr_row_streamer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lwr_row_streamer.sv
// Streams one public-matrix row from a synchronous RAM as a_in/a_valid/a_last,
// pairing every element with its secret-key bit for the dot-product accumulator.
module lwr_row_streamer #(
   parameter int unsigned N_LWR      = 445,
   parameter int unsigned ELEM_WIDTH = 12,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [N_LWR-1:0]      key,
   input  logic                  pause,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [ELEM_WIDTH-1:0] mem_rdata,
   output logic [ELEM_WIDTH-1:0] a_in,
   output logic                  a_valid,
   output logic                  a_last,
   output logic                  key_bit,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned CNT_W = $clog2(N_LWR + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_LWR - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t                  state, state_d;
   logic [N_LWR-1:0]        key_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [CNT_W-1:0]        rd_idx, rd_idx_d;
   logic [CNT_W-1:0]        issue_idx;
   logic [CNT_W-1:0]        mem_idx;
   logic [CNT_W-1:0]        idx_d1;
   logic                    en_d1;
   logic                    issue_c;
   logic                    accept_c;
   logic                    done_c;
   logic [ADDR_WIDTH-1:0]   issue_base;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   // Next-state and issue decisions; the accepting cycle already issues element 0
   always_comb begin
      state_d   = state;
      issue_c   = 1'b0;
      accept_c  = 1'b0;
      issue_idx = rd_idx;
      rd_idx_d  = rd_idx;
      done_c    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept_c  = 1'b1;
               issue_idx = '0;
               rd_idx_d  = '0;
               state_d   = S_ISSUE;
               if (!pause) begin
                  issue_c  = 1'b1;
                  rd_idx_d = CNT_W'(1);
                  if (issue_idx == LAST_IDX) state_d = S_DRAIN;
               end
            end
         end
         S_ISSUE: begin
            if (!pause) begin
               issue_c  = 1'b1;
               rd_idx_d = rd_idx + CNT_W'(1);
               if (rd_idx == LAST_IDX) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (a_valid && a_last) begin
               done_c  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign issue_base = accept_c ? base_addr : addr_r;

   // Issue side: latched request, read counter and registered RAM port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r   <= '0;
         rd_idx   <= '0;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         mem_idx  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (accept_c) addr_r <= base_addr;
         rd_idx   <= rd_idx_d;
         mem_en   <= issue_c;
         if (issue_c) begin
            mem_addr <= issue_base + ADDR_WIDTH'(issue_idx);
            mem_idx  <= issue_idx;
         end
         busy     <= (state_d != S_IDLE);
         done     <= done_c;
      end
   end

   // Return side: elements leave in issue order, so the key is consumed LSB first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r   <= '0;
         en_d1   <= 1'b0;
         idx_d1  <= '0;
         a_in    <= '0;
         a_valid <= 1'b0;
         a_last  <= 1'b0;
         key_bit <= 1'b0;
      end else begin
         en_d1  <= mem_en;
         idx_d1 <= mem_idx;
         if (accept_c) begin
            key_r <= key;
         end else if (en_d1) begin
            key_r <= key_r >> 1;
         end
         if (en_d1) begin
            a_in    <= mem_rdata;
            a_valid <= 1'b1;
            a_last  <= (idx_d1 == LAST_IDX);
            key_bit <= key_r[0];
         end else begin
            a_valid <= 1'b0;
            a_last  <= 1'b0;
            key_bit <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lwr_row_streamer.sv
// Scoreboard bench for lwr_row_streamer at N_LWR = 4, 1 and 445.
module tb_lwr_row_streamer;

   typedef struct {
      int a;
      int kb;
      int last;
      int cyc;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   acc4 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- N_LWR = 4 ----------------
   logic        start4 = 1'b0, pause4 = 1'b0;
   logic [15:0] base4 = '0;
   logic [3:0]  key4 = '0;
   logic        mem_en4, a_valid4, a_last4, key_bit4, busy4, done4;
   logic [15:0] mem_addr4;
   logic [11:0] rdata4, a_in4;
   logic [11:0] mem4 [0:255];

   lwr_row_streamer #(.N_LWR(4), .ELEM_WIDTH(12), .ADDR_WIDTH(16)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .base_addr(base4), .key(key4),
      .pause(pause4), .mem_en(mem_en4), .mem_addr(mem_addr4), .mem_rdata(rdata4),
      .a_in(a_in4), .a_valid(a_valid4), .a_last(a_last4), .key_bit(key_bit4),
      .busy(busy4), .done(done4));

   always @(posedge clk) if (mem_en4) rdata4 <= mem4[mem_addr4[7:0]];

   // ---------------- N_LWR = 1 ----------------
   logic        start1 = 1'b0, pause1 = 1'b0;
   logic [15:0] base1 = '0;
   logic [0:0]  key1 = '0;
   logic        mem_en1, a_valid1, a_last1, key_bit1, busy1, done1;
   logic [15:0] mem_addr1;
   logic [11:0] rdata1, a_in1;
   logic [11:0] mem1 [0:3];

   lwr_row_streamer #(.N_LWR(1), .ELEM_WIDTH(12), .ADDR_WIDTH(16)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base1), .key(key1),
      .pause(pause1), .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(rdata1),
      .a_in(a_in1), .a_valid(a_valid1), .a_last(a_last1), .key_bit(key_bit1),
      .busy(busy1), .done(done1));

   always @(posedge clk) if (mem_en1) rdata1 <= mem1[mem_addr1[1:0]];

   // ---------------- N_LWR = 445 ----------------
   logic         startb = 1'b0, pauseb = 1'b0;
   logic [15:0]  baseb = '0;
   logic [444:0] keyb = '0;
   logic         mem_enb, a_validb, a_lastb, key_bitb, busyb, doneb;
   logic [15:0]  mem_addrb;
   logic [11:0]  rdatab, a_inb;
   logic [11:0]  memb [0:1023];

   lwr_row_streamer #(.N_LWR(445), .ELEM_WIDTH(12), .ADDR_WIDTH(16)) ub (
      .clk(clk), .rst_n(rst_n), .start(startb), .base_addr(baseb), .key(keyb),
      .pause(pauseb), .mem_en(mem_enb), .mem_addr(mem_addrb), .mem_rdata(rdatab),
      .a_in(a_inb), .a_valid(a_validb), .a_last(a_lastb), .key_bit(key_bitb),
      .busy(busyb), .done(doneb));

   always @(posedge clk) if (mem_enb) rdatab <= memb[mem_addrb[9:0]];

   // ---------------- scoreboard ----------------
   beat_t q4[$], q1[$], qb[$];
   int    dq4[$], dq1[$], dqb[$];

   function automatic void cmp(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin : mon4
      beat_t b;
      if (rst_n) begin
         if (a_valid4) begin
            if (q4.size() == 0) cmp("u4 unexpected beat", 1, 0);
            else begin
               b = q4.pop_front();
               cmp("u4 a_in", int'(a_in4), b.a);
               cmp("u4 key_bit", int'(key_bit4), b.kb);
               cmp("u4 a_last", int'(a_last4), b.last);
               cmp("u4 beat cycle", cyc, b.cyc);
               if (key_bit4) acc4 += int'(a_in4);
            end
         end else begin
            cmp("u4 key_bit/a_last when invalid", int'({key_bit4, a_last4}), 0);
         end
         if (done4) begin
            if (dq4.size() == 0) cmp("u4 unexpected done", 1, 0);
            else cmp("u4 done cycle", cyc, dq4.pop_front());
         end
      end
   end

   always @(negedge clk) begin : mon1
      beat_t b;
      if (rst_n) begin
         if (a_valid1) begin
            if (q1.size() == 0) cmp("u1 unexpected beat", 1, 0);
            else begin
               b = q1.pop_front();
               cmp("u1 a_in", int'(a_in1), b.a);
               cmp("u1 key_bit", int'(key_bit1), b.kb);
               cmp("u1 a_last", int'(a_last1), b.last);
               cmp("u1 beat cycle", cyc, b.cyc);
            end
         end
         if (done1) begin
            if (dq1.size() == 0) cmp("u1 unexpected done", 1, 0);
            else cmp("u1 done cycle", cyc, dq1.pop_front());
         end
      end
   end

   always @(negedge clk) begin : monb
      beat_t b;
      if (rst_n) begin
         if (a_validb) begin
            if (qb.size() == 0) cmp("u445 unexpected beat", 1, 0);
            else begin
               b = qb.pop_front();
               if (int'(a_inb) !== b.a || int'(key_bitb) !== b.kb || int'(a_lastb) !== b.last)
                  cmp("u445 beat {a_in,key_bit,a_last}",
                      int'({a_inb, key_bitb, a_lastb}), (b.a << 2) | (b.kb << 1) | b.last);
               else
                  cmp("u445 beat", 1, 1 & int'(a_validb));
               cmp("u445 beat cycle", cyc, b.cyc);
            end
         end
         if (doneb) begin
            if (dqb.size() == 0) cmp("u445 unexpected done", 1, 0);
            else cmp("u445 done cycle", cyc, dqb.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic go4(input logic [15:0] b, input logic [3:0] k, output int t0);
      base4 = b; key4 = k; start4 = 1'b1; t0 = cyc;
      @(negedge clk);
      start4 = 1'b0; base4 = '0; key4 = '0;
   endtask

   task automatic exp4(input int t0, input int d0, input int d1, input int d2, input int d3,
                       input logic [3:0] k, input int gap, input int nbeats);
      int d[4];
      logic [3:0] ks;
      d = '{d0, d1, d2, d3};
      for (int i = 0; i < nbeats; i++) begin
         ks = k >> i;
         q4.push_back('{d[i], int'(ks[0]), (i == 3) ? 1 : 0, t0 + 3 + i + ((i >= 2) ? gap : 0)});
      end
      if (nbeats == 4) dq4.push_back(t0 + 7 + gap);
   endtask

   task automatic drain(input string nm, input int lim);
      int n = 0;
      while ((q4.size() + dq4.size() + q1.size() + dq1.size() + qb.size() + dqb.size()) != 0
             && n < lim) begin
         @(negedge clk); #1;
         n++;
      end
      cmp({nm, " drain pending"}, q4.size() + dq4.size() + q1.size() + dq1.size()
                                  + qb.size() + dqb.size(), 0);
      q4.delete(); dq4.delete(); q1.delete(); dq1.delete(); qb.delete(); dqb.delete();
   endtask

   task automatic exprow(input int t0, input logic [15:0] b, input logic [444:0] k);
      logic [444:0] ks;
      logic [9:0]   ix;
      ks = k;
      for (int i = 0; i < 445; i++) begin
         ix = 10'(int'(b) + i);
         qb.push_back('{int'(memb[ix]), int'(ks[0]), (i == 444) ? 1 : 0, t0 + 3 + i});
         ks = ks >> 1;
      end
      dqb.push_back(t0 + 448);
   endtask

   // ---------------- test sequence ----------------
   initial begin : stim
      int t0;
      int n;
      logic [444:0] ka, kb2;

      for (int i = 0; i < 256; i++) mem4[i] = 12'(i + 200);
      mem4[16] = 12'd5; mem4[17] = 12'd7; mem4[18] = 12'd9; mem4[19] = 12'd11;
      for (int i = 0; i < 4; i++) mem1[i] = 12'h123;
      mem1[0] = 12'hFFF;
      for (int i = 0; i < 1024; i++) memb[i] = 12'($urandom);
      for (int i = 0; i < 445; i++) begin
         ka  = {ka[443:0], 1'($urandom_range(0, 1))};
         kb2 = {kb2[443:0], 1'($urandom_range(0, 1))};
      end

      // reset values
      repeat (2) @(negedge clk);
      cmp("reset a_valid", int'(a_valid4), 0);
      cmp("reset a_in", int'(a_in4), 0);
      cmp("reset mem_en", int'(mem_en4), 0);
      cmp("reset mem_addr", int'(mem_addr4), 0);
      cmp("reset busy/done/a_last/key_bit", int'({busy4, done4, a_last4, key_bit4}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic row, no pause
      acc4 = 0;
      go4(16'h0010, 4'b1011, t0);
      cmp("t1 busy after E0", int'(busy4), 1);
      cmp("t1 mem_en after E0", int'(mem_en4), 1);
      cmp("t1 mem_addr after E0", int'(mem_addr4), 16);
      exp4(t0, 5, 7, 9, 11, 4'b1011, 0, 4);
      drain("t1", 40);
      cmp("t1 accumulator", acc4, 23);
      cmp("t1 busy after done", int'(busy4), 0);
      repeat (2) @(negedge clk);

      // two paused cycles after E1
      acc4 = 0;
      go4(16'h0010, 4'b1011, t0);
      exp4(t0, 5, 7, 9, 11, 4'b1011, 2, 4);
      @(negedge clk);
      pause4 = 1'b1;
      repeat (2) @(negedge clk);
      pause4 = 1'b0;
      drain("t2", 40);
      cmp("t2 accumulator", acc4, 23);
      repeat (2) @(negedge clk);

      // start while busy is ignored
      acc4 = 0;
      go4(16'h0010, 4'b1011, t0);
      exp4(t0, 5, 7, 9, 11, 4'b1011, 0, 4);
      @(negedge clk);
      base4 = 16'h0020; key4 = 4'b0100; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0; base4 = '0; key4 = '0;
      drain("t3", 40);
      cmp("t3 accumulator", acc4, 23);
      repeat (2) @(negedge clk);

      // reset while element 2 is in flight
      go4(16'h0010, 4'b1011, t0);
      exp4(t0, 5, 7, 9, 11, 4'b1011, 0, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      cmp("t4 async reset a_valid", int'(a_valid4), 0);
      cmp("t4 async reset a_in", int'(a_in4), 0);
      cmp("t4 async reset busy", int'(busy4), 0);
      cmp("t4 async reset mem_en/mem_addr", int'({mem_en4, mem_addr4}), 0);
      cmp("t4 async reset done/a_last/key_bit", int'({done4, a_last4, key_bit4}), 0);
      cmp("t4 element 0 seen before reset", q4.size(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      acc4 = 0;
      go4(16'h0010, 4'b1011, t0);
      exp4(t0, 5, 7, 9, 11, 4'b1011, 0, 4);
      drain("t4", 40);
      cmp("t4 accumulator", acc4, 23);

      // N_LWR = 1
      base1 = '0; key1 = 1'b1; start1 = 1'b1; t0 = cyc;
      @(negedge clk);
      start1 = 1'b0; key1 = '0;
      q1.push_back('{32'hFFF, 1, 1, t0 + 3});
      dq1.push_back(t0 + 4);
      drain("t5", 20);
      cmp("t5 busy after done", int'(busy1), 0);

      // N_LWR = 445, second start on the done cycle
      baseb = 16'h0100; keyb = ka; startb = 1'b1; t0 = cyc;
      @(negedge clk);
      startb = 1'b0;
      exprow(t0, 16'h0100, ka);
      n = 0;
      while (!doneb && n < 600) begin
         @(negedge clk);
         n++;
      end
      cmp("t6 first row done seen", int'(doneb), 1);
      baseb = 16'h0040; keyb = kb2; startb = 1'b1; t0 = cyc;
      @(negedge clk);
      startb = 1'b0;
      cmp("t6 busy on second row", int'(busyb), 1);
      exprow(t0, 16'h0040, kb2);
      drain("t6", 1200);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
